// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and buffers words for the controller.
// Define FETCH_PREFETCH_EN for a 2-entry buffer (prefetch); otherwise the buffer holds a single entry.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    typedef enum logic {ISSUE, DISCARD} state_t;
    state_t state, state_next;

    logic [31:0] fetch_pc, fetch_pc_next;
    logic        tail_valid, tail_valid_next;
    logic [31:0] tail_word, tail_word_next;
    logic [31:0] tail_pc, tail_pc_next;
    logic        head_valid_next;
    logic [31:0] head_word_next, head_pc_next;
    logic        req_next;
    logic [31:0] addr_next;
    logic [1:0]  occ_next;
    logic        ack_fire, pop, push;
    logic [31:0] target;
    logic        unused_low_bits;

    assign ack_fire        = imem_req & imem_ack;
    assign pop             = inst_valid & inst_ready;
    assign push            = ack_fire & (state == ISSUE) & ~redirect;
    assign target          = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    // The head entry lives directly in the output registers; pop is applied before push.
    always_comb begin
        head_valid_next = inst_valid;
        head_word_next  = instruction;
        head_pc_next    = inst_pc;
        tail_valid_next = tail_valid;
        tail_word_next  = tail_word;
        tail_pc_next    = tail_pc;
        if (redirect) begin
            head_valid_next = 1'b0;
            head_word_next  = BUBBLE;
            tail_valid_next = 1'b0;
        end else begin
            if (pop) begin
                if (tail_valid) begin
                    head_valid_next = 1'b1;
                    head_word_next  = tail_word;
                    head_pc_next    = tail_pc;
                    tail_valid_next = 1'b0;
                end else begin
                    head_valid_next = 1'b0;
                    head_word_next  = BUBBLE;
                end
            end
            if (push) begin
                if (!head_valid_next) begin
                    head_valid_next = 1'b1;
                    head_word_next  = imem_rdata;
                    head_pc_next    = imem_addr;
                end else begin
                    tail_valid_next = 1'b1;
                    tail_word_next  = imem_rdata;
                    tail_pc_next    = imem_addr;
                end
            end
        end
        occ_next = {1'b0, head_valid_next} + {1'b0, tail_valid_next};
    end

    // While discarding, fetch_pc already holds the saved redirect target.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_next      = imem_req;
        addr_next     = imem_addr;
        if (redirect) begin
            fetch_pc_next = target;
        end else if (state == ISSUE && ack_fire) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end
        case (state)
            ISSUE: begin
                if (imem_req && !imem_ack) begin
                    if (redirect) begin
                        state_next = DISCARD;
                    end
                end else begin
                    req_next  = (occ_next < DEPTH);
                    addr_next = fetch_pc_next;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_next = ISSUE;
                    req_next   = 1'b1;
                    addr_next  = fetch_pc_next;
                end
            end
            default: begin
                state_next = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ISSUE;
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            inst_valid  <= 1'b0;
            instruction <= BUBBLE;
            inst_pc     <= 32'h0000_0000;
            tail_valid  <= 1'b0;
            tail_word   <= BUBBLE;
            tail_pc     <= 32'h0000_0000;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            imem_req    <= req_next;
            imem_addr   <= addr_next;
            inst_valid  <= head_valid_next;
            instruction <= head_word_next;
            inst_pc     <= head_pc_next;
            tail_valid  <= tail_valid_next;
            tail_word   <= tail_word_next;
            tail_pc     <= tail_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// stream-level model (head PC, occupancy, stale outstanding request).
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int passes = 0;

    logic [31:0] exp_pc;
    int          occ;
    logic        stale;
    logic        prev_req;
    logic        prev_fire;
    logic [31:0] prev_addr;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .instruction(instruction),
        .inst_pc(inst_pc),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Drives one cycle from a negedge and advances the reference model to the next negedge.
    task automatic step(input logic ready, input logic ack_en, input logic redir, input logic [31:0] rpc);
        logic fire;
        logic popm;
        inst_ready  = ready;
        imem_ack    = ack_en & imem_req;
        imem_rdata  = mem_word(imem_addr);
        redirect    = redir;
        redirect_pc = rpc;
        fire = imem_req && ack_en;
        popm = (occ > 0) && ready;
        if (popm) exp_pc = exp_pc + 32'd4;
        if (redir) begin
            exp_pc = {rpc[31:2], 2'b00};
            occ    = 0;
            stale  = imem_req && !ack_en;
        end else begin
            occ = occ + ((fire && !stale) ? 1 : 0) - (popm ? 1 : 0);
            if (fire) stale = 1'b0;
        end
        prev_req  = imem_req;
        prev_fire = fire;
        prev_addr = imem_addr;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else passes++;
        checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); else passes++;
        checks++; if (instruction !== BUBBLE) $display("[TB] FAIL reset_instr: got %h expected %h", instruction, BUBBLE); else passes++;
        checks++; if (inst_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h expected 0", inst_pc); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", imem_req); else passes++;
        checks++; if (imem_addr !== 32'h100) $display("[TB] FAIL first_addr: got %h expected 00000100", imem_addr); else passes++;
    endtask

    task automatic test_stream;
        int valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid === 1'b1) valid_cycles++;
            checks++;
            if (inst_valid !== (occ > 0)) $display("[TB] FAIL stream_valid: got %b expected %b", inst_valid, occ > 0); else passes++;
            if (occ > 0) begin
                checks++;
                if (inst_pc !== exp_pc || instruction !== mem_word(exp_pc))
                    $display("[TB] FAIL stream_head: got pc %h word %h expected pc %h word %h", inst_pc, instruction, exp_pc, mem_word(exp_pc));
                else passes++;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (valid_cycles != ((DEPTH == 2) ? 19 : 10))
            $display("[TB] FAIL stream_rate: got %0d valid cycles expected %0d", valid_cycles, (DEPTH == 2) ? 19 : 10);
        else passes++;
    endtask

    task automatic test_backpressure;
        logic [31:0] held_pc;
        held_pc = exp_pc;
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL bp_req: got %b expected 0", imem_req); else passes++;
        checks++; if (inst_valid !== 1'b1) $display("[TB] FAIL bp_valid: got %b expected 1", inst_valid); else passes++;
        checks++;
        if (inst_pc !== held_pc || instruction !== mem_word(held_pc))
            $display("[TB] FAIL bp_hold: got pc %h word %h expected pc %h", inst_pc, instruction, held_pc);
        else passes++;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== (occ > 0)) $display("[TB] FAIL bp_fill: got valid %b expected %b", inst_valid, occ > 0); else passes++;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (inst_valid !== (occ > 0)) $display("[TB] FAIL bp_valid_resume: got %b expected %b", inst_valid, occ > 0); else passes++;
            if (occ > 0) begin
                checks++;
                if (inst_pc !== exp_pc || instruction !== mem_word(exp_pc))
                    $display("[TB] FAIL bp_resume: got pc %h expected pc %h", inst_pc, exp_pc);
                else passes++;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_redirect_wait;
        logic [31:0] old_addr;
        logic        found = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || inst_valid !== 1'b0)
            $display("[TB] FAIL rw_setup: got req %b valid %b expected req 1 valid 0", imem_req, inst_valid);
        else passes++;
        old_addr = imem_addr;
        step(1'b1, 1'b0, 1'b1, 32'h0000_2000);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== old_addr || inst_valid !== 1'b0)
                $display("[TB] FAIL rw_hold: got req %b addr %h valid %b expected req 1 addr %h valid 0", imem_req, imem_addr, inst_valid, old_addr);
            else passes++;
            step(1'b1, (i == 2), 1'b0, 32'h0);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || inst_valid !== 1'b0)
            $display("[TB] FAIL rw_reissue: got req %b addr %h valid %b expected req 1 addr 00002000 valid 0", imem_req, imem_addr, inst_valid);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            if (inst_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (!found || inst_pc !== 32'h2000 || instruction !== mem_word(32'h2000))
            $display("[TB] FAIL rw_first: got found %b pc %h expected pc 00002000", found, inst_pc);
        else passes++;
    endtask

    task automatic test_redirect_ack;
        logic found = 1'b0;
        for (int i = 0; i < 4 && imem_req !== 1'b1; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1) $display("[TB] FAIL ra_setup: got req %b expected 1", imem_req); else passes++;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
            $display("[TB] FAIL ra_flush: got valid %b req %b addr %h expected valid 0 req 1 addr 00000040", inst_valid, imem_req, imem_addr);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            if (inst_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (!found || inst_pc !== 32'h40 || instruction !== mem_word(32'h40))
            $display("[TB] FAIL ra_first: got found %b pc %h expected pc 00000040", found, inst_pc);
        else passes++;
    endtask

    task automatic test_wrap;
        logic found = 1'b0;
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0)
            $display("[TB] FAIL wrap_first: got req %b addr %h valid %b expected req 1 addr fffffffc valid 0", imem_req, imem_addr, inst_valid);
        else passes++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (imem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checks++;
        if (!found || imem_addr !== 32'h0)
            $display("[TB] FAIL wrap_next: got found %b addr %h expected addr 00000000", found, imem_addr);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            if (occ > 0) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== exp_pc)
                    $display("[TB] FAIL wrap_stream: got valid %b pc %h expected pc %h", inst_valid, inst_pc, exp_pc);
                else passes++;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_random;
        logic        ready;
        logic        ack_en;
        logic        redir;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (inst_valid !== (occ > 0)) $display("[TB] FAIL rnd_valid: got %b expected %b", inst_valid, occ > 0); else passes++;
            checks++;
            if (occ > 0) begin
                if (inst_pc !== exp_pc || instruction !== mem_word(exp_pc))
                    $display("[TB] FAIL rnd_head: got pc %h word %h expected pc %h word %h", inst_pc, instruction, exp_pc, mem_word(exp_pc));
                else passes++;
            end else begin
                if (instruction !== BUBBLE) $display("[TB] FAIL rnd_bubble: got %h expected %h", instruction, BUBBLE); else passes++;
            end
            checks++;
            if (imem_addr[1:0] !== 2'b00) $display("[TB] FAIL rnd_align: got %h expected low bits 0", imem_addr); else passes++;
            checks++;
            if (prev_req && !prev_fire) begin
                if (imem_req !== 1'b1 || imem_addr !== prev_addr)
                    $display("[TB] FAIL rnd_hold: got req %b addr %h expected req 1 addr %h", imem_req, imem_addr, prev_addr);
                else passes++;
            end else begin
                if (imem_req !== (occ < DEPTH))
                    $display("[TB] FAIL rnd_req: got %b expected %b", imem_req, occ < DEPTH);
                else if (occ < DEPTH && imem_addr !== exp_pc + 32'(4 * occ))
                    $display("[TB] FAIL rnd_addr: got %h expected %h", imem_addr, exp_pc + 32'(4 * occ));
                else passes++;
            end
            ready  = ($urandom_range(0, 3) != 0);
            ack_en = ($urandom_range(0, 1) == 1);
            redir  = ($urandom_range(0, 19) == 0);
            rpc    = $urandom;
            step(ready, ack_en, redir, rpc);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 6 && imem_req !== 1'b1; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1) $display("[TB] FAIL ar_setup: got req %b expected 1", imem_req); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || instruction !== BUBBLE || imem_addr !== 32'h100)
            $display("[TB] FAIL ar_clear: got req %b valid %b instr %h addr %h expected 0 0 %h 00000100", imem_req, inst_valid, instruction, BUBBLE, imem_addr);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        exp_pc      = 32'h100;
        occ         = 0;
        stale       = 1'b0;
        prev_req    = 1'b0;
        prev_fire   = 1'b0;
        prev_addr   = 32'h0;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_wait;
        test_redirect_ack;
        test_wrap;
        test_random;
        test_async_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
